// File: rtl/matmul_pkg.sv
// Shared types and width helpers for the matrix-multiply job scheduler.
package matmul_pkg;

  // Scheduler FSM states: one job moves IDLE -> LAUNCH -> WAIT -> RESP -> IDLE.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } sched_state_e;

  // Ceiling log2 that never returns less than one bit, so that degenerate
  // parameter values still yield legal vector widths.
  function automatic int clog2_min1(input int v);
    return ($clog2(v) < 1) ? 1 : $clog2(v);
  endfunction

  // Width of one requester's slot index.
  function automatic int slot_w(input int max_matrices);
    return clog2_min1(max_matrices);
  endfunction

  // Width of the operand base address (slot * array dimension).
  function automatic int addr_w(input int array_size, input int max_matrices);
    return clog2_min1(array_size * max_matrices);
  endfunction

  // Width of a requester index.
  function automatic int id_w(input int num_req);
    return clog2_min1(num_req);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational grant search starting just after the
// last granted requester, with the last-grant pointer held in a register.
module rr_arbiter
  import matmul_pkg::*;
#(
  parameter int N    = 2,
  parameter int ID_W = id_w(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    i_req,
  input  logic            i_advance,
  output logic [N-1:0]    o_grant,
  output logic [ID_W-1:0] o_grant_id,
  output logic            o_any
);

  logic [ID_W-1:0] r_last;
  logic [N-1:0]    w_grant;
  logic [ID_W-1:0] w_grant_id;
  logic            w_any;

  // Requester index k positions after base, wrapping at N.
  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int k);
    return ID_W'((int'(base) + k) % N);
  endfunction

  // Search (last+1) mod N upward; the first requester found wins.
  always_comb begin
    w_grant    = '0;
    w_grant_id = '0;
    w_any      = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!w_any && i_req[wrap_idx(r_last, k)]) begin
        w_any      = 1'b1;
        w_grant_id = wrap_idx(r_last, k);
      end
    end
    if (w_any) begin
      w_grant = N'(1) << w_grant_id;
    end
  end

  // Pointer starts at N-1 so requester 0 has priority after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= ID_W'(N - 1);
    end else if (i_advance) begin
      r_last <= w_grant_id;
    end
  end

  assign o_grant    = w_grant;
  assign o_grant_id = w_grant_id;
  assign o_any      = w_any;

endmodule

// File: rtl/matmul_scheduler.sv
// Job scheduler in front of a shared systolic array: arbitrates requesters
// round-robin, launches one job at a time, watches for completion or
// timeout and returns a one-cycle response to the owning requester.
module matmul_scheduler
  import matmul_pkg::*;
#(
  parameter int ARRAY_SIZE     = 3,
  parameter int MAX_MATRICES   = 2,
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [NUM_REQ-1:0]                           req_valid,
  input  logic [NUM_REQ*slot_w(MAX_MATRICES)-1:0]      req_slot,
  output logic [NUM_REQ-1:0]                           req_accept,
  output logic [NUM_REQ-1:0]                           rsp_valid,
  output logic                                         rsp_error,
  output logic                                         arr_start,
  input  logic                                         arr_busy,
  input  logic                                         arr_done,
  output logic [addr_w(ARRAY_SIZE, MAX_MATRICES)-1:0]  arr_base,
  output logic [id_w(NUM_REQ)-1:0]                     active_id,
  output logic                                         sched_busy
);

  localparam int SLOT_W = slot_w(MAX_MATRICES);
  localparam int ADDR_W = addr_w(ARRAY_SIZE, MAX_MATRICES);
  localparam int ID_W   = id_w(NUM_REQ);
  localparam int CNT_W  = clog2_min1(TIMEOUT_CYCLES);

  sched_state_e         r_state;
  logic [CNT_W-1:0]     r_count;
  logic                 r_arr_start;
  logic [NUM_REQ-1:0]   r_rsp_valid;
  logic                 r_rsp_error;
  logic [ADDR_W-1:0]    r_arr_base;
  logic [ID_W-1:0]      r_active_id;

  logic [NUM_REQ-1:0]   w_grant;
  logic [ID_W-1:0]      w_grant_id;
  logic                 w_any;
  logic                 w_grant_en;
  logic [SLOT_W-1:0]    w_slot_raw;
  logic [SLOT_W-1:0]    w_slot;
  logic [ADDR_W-1:0]    w_base;
  logic                 w_timeout;

  // Out-of-range slot indices fall back to the highest populated slot.
  function automatic logic [SLOT_W-1:0] clamp_slot(input logic [SLOT_W-1:0] s);
    if (int'(s) >= MAX_MATRICES) begin
      return SLOT_W'(MAX_MATRICES - 1);
    end
    return s;
  endfunction

  rr_arbiter #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_arb (
    .clk        (clk),
    .rst        (rst),
    .i_req      (req_valid),
    .i_advance  (w_grant_en),
    .o_grant    (w_grant),
    .o_grant_id (w_grant_id),
    .o_any      (w_any)
  );

  // A grant is only possible from IDLE with the array free. The acceptance
  // pulse is combinational so the requester sees it in the grant cycle and
  // can drop its request at the following edge; it is forced low under
  // reset so that every output reads 0 while rst is high.
  assign w_grant_en = (r_state == IDLE) && !arr_busy && w_any && !rst;
  assign req_accept = w_grant_en ? w_grant : '0;

  // Slot of the winning requester, clamped and scaled to an operand address.
  assign w_slot_raw = req_slot[w_grant_id*SLOT_W +: SLOT_W];
  assign w_slot     = clamp_slot(w_slot_raw);
  assign w_base     = ADDR_W'(int'(w_slot) * ARRAY_SIZE);

  // Last WAIT cycle before the job is declared lost.
  assign w_timeout  = (r_count == CNT_W'(TIMEOUT_CYCLES - 1));

  // Job sequencing FSM; pulses default low and are raised for one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_arr_start <= 1'b0;
      r_rsp_valid <= '0;
      r_rsp_error <= 1'b0;
      r_arr_base  <= '0;
      r_active_id <= '0;
    end else begin
      r_arr_start <= 1'b0;
      r_rsp_valid <= '0;
      r_rsp_error <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_en) begin
            // arr_start is visible during LAUNCH, one cycle after the grant.
            r_state     <= LAUNCH;
            r_arr_start <= 1'b1;
            r_arr_base  <= w_base;
            r_active_id <= w_grant_id;
          end
        end
        LAUNCH: begin
          r_count <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          // arr_done takes priority over a coincident timeout.
          if (arr_done) begin
            r_state     <= RESP;
            r_rsp_valid <= NUM_REQ'(1) << r_active_id;
            r_rsp_error <= 1'b0;
          end else if (w_timeout) begin
            r_state     <= RESP;
            r_rsp_valid <= NUM_REQ'(1) << r_active_id;
            r_rsp_error <= 1'b1;
          end else begin
            r_count <= r_count + CNT_W'(1);
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign arr_start  = r_arr_start;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_error  = r_rsp_error;
  assign arr_base   = r_arr_base;
  assign active_id  = r_active_id;
  assign sched_busy = (r_state != IDLE);

endmodule

// File: tb/tb_matmul_scheduler.sv
// Directed bench for matmul_scheduler: single jobs, round-robin order,
// timeout, done-in-last-cycle, busy hold-off, slot clamping and reset.
module tb_matmul_scheduler;

  localparam int AS = 3;
  localparam int MM = 3;
  localparam int NR = 2;
  localparam int T  = 64;

  logic       clk       = 1'b0;
  logic       rst       = 1'b1;
  logic [1:0] req_valid = 2'b00;
  logic [3:0] req_slot  = 4'h0;
  logic       arr_busy  = 1'b0;
  logic       arr_done  = 1'b0;

  logic [1:0] req_accept;
  logic [1:0] rsp_valid;
  logic       rsp_error;
  logic       arr_start;
  logic [3:0] arr_base;
  logic [0:0] active_id;
  logic       sched_busy;

  int n_cmp = 0;
  int n_bad = 0;

  matmul_scheduler #(
    .ARRAY_SIZE     (AS),
    .MAX_MATRICES   (MM),
    .NUM_REQ        (NR),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_slot   (req_slot),
    .req_accept (req_accept),
    .rsp_valid  (rsp_valid),
    .rsp_error  (rsp_error),
    .arr_start  (arr_start),
    .arr_busy   (arr_busy),
    .arr_done   (arr_done),
    .arr_base   (arr_base),
    .active_id  (active_id),
    .sched_busy (sched_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] oh(input int id);
    return 2'b01 << id;
  endfunction

  // Step to just after the next rising edge (inputs are driven here).
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Move to the falling edge of the current cycle (outputs are sampled here).
  task automatic settle();
    @(negedge clk);
  endtask

  // Run one job from its IDLE grant cycle through its RESP cycle.
  // d = cycles from arr_start to the arr_done pulse, or -1 for no arr_done.
  task automatic do_job(input int id, input int d, input logic err,
                        input int base, input bit keep);
    int rsp_k;
    rsp_k = (d < 0) ? T + 1 : d + 1;
    settle();
    chk("idle_busy", 32'(sched_busy), 32'd0);
    chk("accept", 32'(req_accept), 32'(oh(id)));
    next();
    if (!keep) req_valid[id] = 1'b0;
    settle();
    chk("arr_start", 32'(arr_start), 32'd1);
    chk("arr_base", 32'(arr_base), 32'(base));
    chk("active_id", 32'(active_id), 32'(id));
    chk("launch_accept", 32'(req_accept), 32'd0);
    chk("launch_busy", 32'(sched_busy), 32'd1);
    for (int k = 1; k <= rsp_k; k++) begin
      next();
      arr_done = (k == d);
      settle();
      if (k == 1) chk("start_pulse_end", 32'(arr_start), 32'd0);
      if (k == rsp_k - 1) chk("rsp_early", 32'(rsp_valid), 32'd0);
      if (k == rsp_k) begin
        chk("rsp_valid", 32'(rsp_valid), 32'(oh(id)));
        chk("rsp_error", 32'(rsp_error), 32'(err));
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    // Reset state
    settle();
    chk("rst_accept", 32'(req_accept), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_error", 32'(rsp_error), 32'd0);
    chk("rst_arr_start", 32'(arr_start), 32'd0);
    chk("rst_arr_base", 32'(arr_base), 32'd0);
    chk("rst_active_id", 32'(active_id), 32'd0);
    chk("rst_sched_busy", 32'(sched_busy), 32'd0);
    next();
    next();
    rst = 1'b0;

    // Requester 0, slot 1 -> base 3, arr_done 8 cycles after arr_start
    next();
    req_valid = 2'b01;
    req_slot  = {2'd0, 2'd1};
    do_job(0, 8, 1'b0, 3, 1'b0);

    // Requester 1, slot 3 clamps to slot 2 -> base 6, done in first WAIT cycle
    next();
    req_valid = 2'b10;
    req_slot  = {2'd3, 2'd0};
    do_job(1, 1, 1'b0, 6, 1'b0);

    // Requester 0, slot 0, arr_done never arrives -> timeout
    next();
    req_valid = 2'b01;
    req_slot  = {2'd1, 2'd0};
    do_job(0, -1, 1'b1, 0, 1'b0);

    // Array busy after the timeout: request from 1 is held off
    next();
    arr_busy  = 1'b1;
    req_valid = 2'b10;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("busy_no_accept", 32'(req_accept), 32'd0);
      chk("busy_idle", 32'(sched_busy), 32'd0);
      next();
    end
    arr_busy = 1'b0;
    // Grant as soon as busy falls; arr_done in the final timeout cycle wins
    do_job(1, T, 1'b0, 3, 1'b0);

    // arr_done outside WAIT is ignored
    next();
    arr_done = 1'b1;
    settle();
    chk("stray_done_busy", 32'(sched_busy), 32'd0);
    next();
    arr_done = 1'b0;
    settle();
    chk("stray_done_rsp", 32'(rsp_valid), 32'd0);
    chk("stray_done_idle", 32'(sched_busy), 32'd0);

    // Reset in WAIT aborts the job
    next();
    req_valid = 2'b01;
    req_slot  = {2'd0, 2'd1};
    settle();
    chk("pre_rst_accept", 32'(req_accept), 32'd1);
    next();
    req_valid = 2'b00;
    next();
    next();
    settle();
    chk("pre_rst_busy", 32'(sched_busy), 32'd1);
    next();
    rst       = 1'b1;
    req_valid = 2'b01;
    #1;
    chk("mid_rst_accept", 32'(req_accept), 32'd0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_arr_start", 32'(arr_start), 32'd0);
    chk("mid_rst_arr_base", 32'(arr_base), 32'd0);
    chk("mid_rst_busy", 32'(sched_busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("rst_no_rsp", 32'(rsp_valid), 32'd0);
      next();
    end
    rst       = 1'b0;
    req_valid = 2'b11;
    req_slot  = {2'd2, 2'd1};

    // Both requesters held: grants 0, 1, 0
    do_job(0, 2, 1'b0, 3, 1'b1);
    next();
    do_job(1, 3, 1'b0, 6, 1'b1);
    next();
    do_job(0, 4, 1'b0, 3, 1'b1);
    next();
    req_valid = 2'b00;
    settle();
    chk("final_idle", 32'(sched_busy), 32'd0);
    chk("final_accept", 32'(req_accept), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/matmul_scheduler.md
MATMUL_SCHEDULER -- requirements
Module: matmul_scheduler

Interface
REQ-001 The block SHALL have parameter ARRAY_SIZE, default 3, giving the systolic array dimension.
REQ-002 The block SHALL have parameter MAX_MATRICES, default 2, giving the number of matrix slots in operand memory.
REQ-003 The block SHALL have parameter NUM_REQ, default 2, giving the number of requesters sharing the array.
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 64, giving the maximum wait for arr_done after launch.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port req_valid, input, NUM_REQ bits: per-requester job request, held until accepted.
REQ-008 The block SHALL have port req_slot, input, NUM_REQ*SLOT_W bits: per-requester matrix slot index, SLOT_W = clog2(MAX_MATRICES), minimum 1.
REQ-009 The block SHALL have port req_accept, output, NUM_REQ bits: one-cycle one-hot acceptance pulse.
REQ-010 The block SHALL have port rsp_valid, output, NUM_REQ bits: one-cycle one-hot completion pulse.
REQ-011 The block SHALL have port rsp_error, output, 1 bit: qualifies rsp_valid; 1 = timeout.
REQ-012 The block SHALL have port arr_start, output, 1 bit: start pulse to the systolic array.
REQ-013 The block SHALL have port arr_busy, input, 1 bit: array busy indication.
REQ-014 The block SHALL have port arr_done, input, 1 bit: array done pulse.
REQ-015 The block SHALL have port arr_base, output, ADDR_W bits: operand base address = slot*ARRAY_SIZE, with ADDR_W = clog2(ARRAY_SIZE*MAX_MATRICES).
REQ-016 The block SHALL have port active_id, output, clog2(NUM_REQ) bits (minimum 1): owner of the current job.
REQ-017 The block SHALL have port sched_busy, output, 1 bit: high in every state except IDLE.

Function
REQ-018 The FSM SHALL use states IDLE, LAUNCH, WAIT, RESP, with transitions IDLE->LAUNCH, LAUNCH->WAIT, WAIT->RESP and RESP->IDLE.
REQ-019 In IDLE, when any req_valid is high and arr_busy is 0, the block SHALL grant one requester round-robin, pulse its req_accept bit, latch its slot into arr_base and its index into active_id, and go to LAUNCH.
REQ-020 Round-robin arbitration SHALL search from (last_grant+1) mod NUM_REQ upward, and last_grant SHALL update on each grant.
REQ-021 While arr_busy is 1 in IDLE, no grant SHALL be issued, and pending requests SHALL be held.
REQ-022 In LAUNCH, the block SHALL assert arr_start for exactly one cycle, clear the timeout counter, and go to WAIT.
REQ-023 In WAIT, the timeout counter SHALL increment each cycle; arr_done=1 SHALL go to RESP with error=0, and counter == TIMEOUT_CYCLES-1 without arr_done SHALL go to RESP with error=1.
REQ-024 If arr_done and the timeout coincide in the same cycle, arr_done SHALL win and error SHALL be 0.
REQ-025 arr_done received outside WAIT SHALL be ignored.
REQ-026 In RESP, the block SHALL pulse rsp_valid[active_id] and drive rsp_error for one cycle, then return to IDLE.
REQ-027 Grant-to-arr_start latency SHALL be 1 cycle, and arr_done-to-rsp_valid latency SHALL be 1 cycle.
REQ-028 Slot values >= MAX_MATRICES SHALL be clamped to MAX_MATRICES-1.
REQ-029 arr_base and active_id SHALL hold their values from grant until the next grant.
REQ-030 At most one job SHALL be outstanding at any time.

Reset
REQ-031 On rst, the FSM SHALL enter IDLE and all outputs SHALL be 0, with last_grant = NUM_REQ-1 so that requester 0 wins first.
REQ-032 A reset asserted mid-job SHALL abort the job with no rsp_valid pulse, and the requester SHALL re-request.

Structure
REQ-033 The state enum and SLOT_W/ADDR_W helper functions SHALL reside in shared package matmul_pkg.
REQ-034 The round-robin arbiter SHALL be sub-module rr_arbiter, combinational grant logic with a registered pointer.

Verification
REQ-035 The bench SHALL cover: req_valid=01, slot 1, ARRAY_SIZE=3 -> req_accept=01, arr_base=3, arr_start one cycle later, and with arr_done 8 cycles later -> rsp_valid=01, rsp_error=0.
REQ-036 The bench SHALL cover: req_valid=11 held across three jobs -> grants 0, 1, 0 in that order.
REQ-037 The bench SHALL cover: arr_done never arriving -> rsp_error=1 with rsp_valid exactly TIMEOUT_CYCLES+1 cycles after arr_start.
REQ-038 The bench SHALL cover: arr_done arriving in the final timeout cycle -> rsp_error=0.
REQ-039 The bench SHALL cover: arr_busy=1 after a timeout -> no grant until arr_busy falls, then grant on the next cycle.
REQ-040 The bench SHALL cover: rst asserted in WAIT -> all outputs 0 immediately, no rsp_valid, and the next grant goes to requester 0.
